// File: rtl/alu_control_mdu.sv
// ALU control decoder for the EX stage plus an iterative RV32M multiply/divide
// unit. The decode is purely combinational. The MDU runs one radix-2 step per
// cycle and holds the pipeline with a stall/done handshake.
module alu_control_mdu #(
    parameter int unsigned XLEN     = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            Inst_30,
    input  logic            Inst_25,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALU_Selection,
    output logic            mdu_sel,
    output logic            stall,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_result
);

    localparam int unsigned CW = $clog2(XLEN);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    // Multiply: {partial product, remaining multiplier}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic                mdu_req;
    logic                a_signed, b_signed, sa, sb, is_div;
    logic                div_zero, div_ovf, start_neg;
    logic [XLEN-1:0]     mag_a, mag_b, fast_res;
    logic [XLEN:0]       mul_sum, div_trial, div_diff;
    logic [2*XLEN-1:0]   mul_next, div_next, step_next, prod_signed;
    logic [XLEN-1:0]     quo, rem, final_res;

    assign mdu_req    = ENABLE_M && in_valid && !flush && (ALUOp == 2'b10) && Inst_25;
    assign mdu_sel    = mdu_req;
    assign mdu_result = result_q;

    // ALU opcode decode from ALUOp/funct3/funct7 bits
    always_comb begin
        ALU_Selection = ALU_PASS;
        case (ALUOp)
            2'b00: ALU_Selection = ALU_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: ALU_Selection = ALU_SUB;
                    3'b100, 3'b101: ALU_Selection = ALU_SLT;
                    3'b110, 3'b111: ALU_Selection = ALU_SLTU;
                    default:        ALU_Selection = ALU_PASS;
                endcase
            end
            2'b10: begin
                if (!Inst_25) begin
                    case ({Inst_30, funct3})
                        4'b0000: ALU_Selection = ALU_ADD;
                        4'b1000: ALU_Selection = ALU_SUB;
                        4'b0001: ALU_Selection = ALU_SLL;
                        4'b0010: ALU_Selection = ALU_SLT;
                        4'b0011: ALU_Selection = ALU_SLTU;
                        4'b0100: ALU_Selection = ALU_XOR;
                        4'b0101: ALU_Selection = ALU_SRL;
                        4'b1101: ALU_Selection = ALU_SRA;
                        4'b0110: ALU_Selection = ALU_OR;
                        4'b0111: ALU_Selection = ALU_AND;
                        default: ALU_Selection = ALU_PASS;
                    endcase
                end
            end
            default: begin
                case (funct3)
                    3'b000:  ALU_Selection = ALU_ADD;
                    3'b001:  ALU_Selection = ALU_SLL;
                    3'b010:  ALU_Selection = ALU_SLT;
                    3'b011:  ALU_Selection = ALU_SLTU;
                    3'b100:  ALU_Selection = ALU_XOR;
                    3'b101:  ALU_Selection = Inst_30 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALU_Selection = ALU_OR;
                    default: ALU_Selection = ALU_AND;
                endcase
            end
        endcase
        if (mdu_req) begin
            ALU_Selection = ALU_PASS;
        end
    end

    // Operand preparation at start: magnitudes, result sign, divide special cases
    always_comb begin
        a_signed  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        b_signed  = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        is_div    = funct3[2];
        sa        = a_signed && op_a[XLEN-1];
        sb        = b_signed && op_b[XLEN-1];
        mag_a     = sa ? -op_a : op_a;
        mag_b     = sb ? -op_b : op_b;
        // Remainder follows the dividend; quotient/product follows both signs.
        start_neg = (is_div && funct3[1]) ? sa : (sa ^ sb);
        div_zero  = is_div && (op_b == '0);
        div_ovf   = is_div && !funct3[0] && (op_a == MIN_INT) && (op_b == '1);
        fast_res  = '0;
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : '1;
        end else if (div_ovf) begin
            fast_res = funct3[1] ? '0 : MIN_INT;
        end
    end

    // One radix-2 iteration and final sign correction / result selection
    always_comb begin
        mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next    = {mul_sum, acc_q[XLEN-1:1]};
        div_trial   = acc_q[2*XLEN-1:XLEN-1];
        div_diff    = div_trial - {1'b0, opnd_q};
        div_next    = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
        step_next   = op_q[2] ? div_next : mul_next;
        prod_signed = neg_q ? -step_next : step_next;
        quo         = step_next[XLEN-1:0];
        rem         = step_next[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 final_res = prod_signed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod_signed[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = neg_q ? -quo : quo;
            default:                final_res = neg_q ? -rem : rem;
        endcase
    end

    // MDU control: next state, datapath updates, stall and done
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        stall    = 1'b0;
        mdu_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mdu_req) begin
                    stall = 1'b1;
                    op_d  = funct3;
                    neg_d = start_neg;
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
                        opnd_d  = is_div ? mag_b : mag_a;
                        count_d = CW'(XLEN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_next;
                    if (count_q == '0) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: begin
                mdu_done = !flush;
                state_d  = S_IDLE;
            end
        endcase
    end

    // MDU state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_control_mdu.sv
// Self-checking bench for alu_control_mdu: decode sweep, directed and random
// RV32M operations against an arithmetic reference, flush, back-to-back,
// reset mid-operation, and a build without the M extension.
module tb_alu_control_mdu;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0001;
    localparam logic [3:0] PASS = 4'b0010;
    localparam logic [3:0] OR_  = 4'b0100;
    localparam logic [3:0] AND_ = 4'b0101;
    localparam logic [3:0] XOR_ = 4'b0111;
    localparam logic [3:0] SRL  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b1001;
    localparam logic [3:0] SRA  = 4'b1010;
    localparam logic [3:0] SLT  = 4'b1101;
    localparam logic [3:0] SLTU = 4'b1111;

    logic        clk, rst_n;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic        Inst_30, Inst_25, in_valid, flush;
    logic [31:0] op_a, op_b;

    logic [3:0]  ALU_Selection, ALU_Selection_n;
    logic        mdu_sel, stall, mdu_done;
    logic        mdu_sel_n, stall_n, mdu_done_n;
    logic [31:0] mdu_result, mdu_result_n;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_exp = '0;

    alu_control_mdu #(.XLEN(32), .ENABLE_M(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .funct3(funct3),
        .Inst_30(Inst_30), .Inst_25(Inst_25), .in_valid(in_valid), .flush(flush),
        .op_a(op_a), .op_b(op_b), .ALU_Selection(ALU_Selection), .mdu_sel(mdu_sel),
        .stall(stall), .mdu_done(mdu_done), .mdu_result(mdu_result)
    );

    alu_control_mdu #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .funct3(funct3),
        .Inst_30(Inst_30), .Inst_25(Inst_25), .in_valid(in_valid), .flush(flush),
        .op_a(op_a), .op_b(op_b), .ALU_Selection(ALU_Selection_n), .mdu_sel(mdu_sel_n),
        .stall(stall_n), .mdu_done(mdu_done_n), .mdu_result(mdu_result_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected ALU opcode from instruction semantics
    function automatic logic [3:0] ref_sel(input logic [1:0] aluop, input logic [2:0] f3,
                                           input logic i30, input logic i25, input logic mreq);
        logic [3:0] base [8];
        base = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
        if (mreq) return PASS;
        if (aluop == 2'd0) return ADD;
        if (aluop == 2'd1) begin
            if (f3[2:1] == 2'b01) return PASS;
            if (!f3[2]) return SUB;
            return f3[1] ? SLTU : SLT;
        end
        if (aluop == 2'd2) begin
            if (i25) return PASS;
            if (!i30) return base[f3];
            if (f3 == 3'd0) return SUB;
            if (f3 == 3'd5) return SRA;
            return PASS;
        end
        if (f3 == 3'd5 && i30) return SRA;
        return base[f3];
    endfunction

    // Expected M-extension result and stall length from plain arithmetic
    function automatic void ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output int lat);
        longint          sa, sb, ub, p;
        longint unsigned up;
        int              ia, ib, iq;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'(b);
        ia  = a;
        ib  = b;
        lat = 33;
        r   = '0;
        case (f3)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin up = longint'(a) * longint'(b); r = up[63:32]; end
            3'd4: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
                else begin iq = ia / ib; r = iq; end
            end
            3'd5: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; lat = 1; end
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) begin r = a; lat = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
                else begin iq = ia % ib; r = iq; end
            end
            default: begin
                if (b == 0) begin r = a; lat = 1; end
                else r = a % b;
            end
        endcase
    endfunction

    task automatic idle_inputs();
        ALUOp = 2'b00; funct3 = 3'b000; Inst_30 = 1'b0; Inst_25 = 1'b0;
        in_valid = 1'b0; flush = 1'b0; op_a = '0; op_b = '0;
    endtask

    task automatic drive_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        ALUOp = 2'b10; funct3 = f3; Inst_30 = 1'b0; Inst_25 = 1'b1;
        in_valid = 1'b1; flush = 1'b0; op_a = a; op_b = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
        total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", mdu_done); end
        total++; if (mdu_result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h expected 0", mdu_result); end
        total++; if (mdu_sel !== 1'b0) begin bad++; $display("FAIL reset_sel: got %b expected 0", mdu_sel); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_decode();
        logic [3:0] exp;
        for (int op = 0; op < 4; op++)
            for (int f = 0; f < 8; f++)
                for (int i30 = 0; i30 < 2; i30++)
                    for (int i25 = 0; i25 < 2; i25++) begin
                        @(negedge clk);
                        idle_inputs();
                        ALUOp = 2'(op); funct3 = 3'(f); Inst_30 = 1'(i30); Inst_25 = 1'(i25);
                        #1;
                        exp = ref_sel(ALUOp, funct3, Inst_30, Inst_25, 1'b0);
                        total++;
                        if (ALU_Selection !== exp || ALU_Selection_n !== exp) begin
                            bad++;
                            $display("FAIL decode %0d/%0d/%0d/%0d: got %b,%b expected %b",
                                     op, f, i30, i25, ALU_Selection, ALU_Selection_n, exp);
                        end
                    end
        // Valid instructions that must not start the MDU
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            ALUOp = 2'($urandom_range(0, 3)); funct3 = 3'($urandom_range(0, 7));
            Inst_30 = 1'($urandom_range(0, 1)); Inst_25 = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            flush = (ALUOp == 2'b10 && Inst_25) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            exp = ref_sel(ALUOp, funct3, Inst_30, Inst_25, 1'b0);
            total++;
            if (ALU_Selection !== exp || stall !== 1'b0 || mdu_sel !== 1'b0) begin
                bad++;
                $display("FAIL decode_valid %0d: got sel=%b stall=%b msel=%b expected sel=%b stall=0 msel=0",
                         k, ALU_Selection, stall, mdu_sel, exp);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic run_mdu(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        int          n;
        ref_mdu(f3, a, b, exp, lat);
        @(negedge clk);
        drive_mop(f3, a, b);
        #1;
        total++; if (mdu_sel !== 1'b1) begin bad++; $display("FAIL %s msel: got %b expected 1", name, mdu_sel); end
        total++; if (ALU_Selection !== PASS) begin bad++; $display("FAIL %s alusel: got %b expected %b", name, ALU_Selection, PASS); end
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            total++;
            if (mdu_done !== 1'b0) begin bad++; $display("FAIL %s early_done: got %b expected 0 at stall cycle %0d", name, mdu_done, n); end
            n++;
            @(negedge clk);
            #1;
        end
        total++; if (n != lat) begin bad++; $display("FAIL %s stall_cycles: got %0d expected %0d", name, n, lat); end
        total++; if (mdu_done !== 1'b1) begin bad++; $display("FAIL %s done: got %b expected 1", name, mdu_done); end
        total++; if (mdu_result !== exp) begin bad++; $display("FAIL %s result: got %h expected %h", name, mdu_result, exp); end
        last_exp = exp;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (mdu_done !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL %s after: got done=%b stall=%b expected 0,0", name, mdu_done, stall); end
        total++; if (mdu_result !== exp) begin bad++; $display("FAIL %s hold: got %h expected %h", name, mdu_result, exp); end
    endtask

    task automatic test_mdu_directed();
        run_mdu("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD);
        run_mdu("MULH",   3'd1, 32'h8000_0000,  32'h8000_0000);
        run_mdu("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_mdu("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
        run_mdu("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2);
        run_mdu("REM",    3'd6, 32'hFFFF_FFF9,  32'd2);
        run_mdu("DIVU",   3'd5, 32'd100,        32'd7);
        run_mdu("REMU",   3'd7, 32'd100,        32'd7);
        run_mdu("DIVU0",  3'd5, 32'd5,          32'd0);
        run_mdu("REM0",   3'd6, 32'd5,          32'd0);
        run_mdu("DIVOVF", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        run_mdu("REMOVF", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    endtask

    task automatic test_mdu_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          kind;
        for (int k = 0; k < 16; k++) begin
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            kind = $urandom_range(0, 7);
            if (kind == 0) b = 32'h0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) b = 32'($urandom_range(1, 15));
            run_mdu("rand", f3, a, b);
        end
    endtask

    task automatic test_flush();
        int dones;
        @(negedge clk);
        drive_mop(3'd0, $urandom, $urandom);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL flush_calc_stall: got %b expected 1", stall); end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (stall !== 1'b0 || mdu_done !== 1'b0) begin bad++; $display("FAIL flush_idle: got stall=%b done=%b expected 0,0", stall, mdu_done); end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (mdu_done !== 1'b0) dones++;
        end
        total++; if (dones != 0) begin bad++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones); end
        total++; if (mdu_result !== last_exp) begin bad++; $display("FAIL flush_result: got %h expected %h", mdu_result, last_exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, e1, e2;
        int          l1, l2, d1, d2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        ref_mdu(3'd0, a1, b1, e1, l1);
        ref_mdu(3'd0, a2, b2, e2, l2);
        d1 = -1;
        d2 = -1;
        for (int cyc = 0; cyc < 200 && d2 < 0; cyc++) begin
            @(negedge clk);
            if (cyc == 0) drive_mop(3'd0, a1, b1);
            if (d1 >= 0 && cyc == d1 + 1) drive_mop(3'd0, a2, b2);
            #1;
            if (mdu_done === 1'b1) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    total++; if (mdu_result !== e1) begin bad++; $display("FAIL b2b_first: got %h expected %h", mdu_result, e1); end
                end else begin
                    d2 = cyc;
                    total++; if (mdu_result !== e2) begin bad++; $display("FAIL b2b_second: got %h expected %h", mdu_result, e2); end
                end
            end
        end
        total++; if (d1 != 33) begin bad++; $display("FAIL b2b_first_cycle: got %0d expected 33", d1); end
        total++; if (d2 - d1 != 34) begin bad++; $display("FAIL b2b_spacing: got %0d expected 34", d2 - d1); end
        last_exp = e2;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        drive_mop(3'd0, 32'd7, 32'hFFFF_FFFD);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
        total++; if (mdu_done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b expected 0", mdu_done); end
        total++; if (mdu_result !== 32'h0) begin bad++; $display("FAIL rst_mid_result: got %h expected 0", mdu_result); end
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = '0;
        run_mdu("post_reset_DIVU", 3'd5, 32'd100, 32'd7);
    endtask

    task automatic test_no_m();
        @(negedge clk);
        drive_mop(3'd0, $urandom, $urandom);
        for (int i = 1; i <= 34; i++) begin
            #1;
            total++;
            if (stall_n !== 1'b0 || mdu_sel_n !== 1'b0 || ALU_Selection_n !== PASS || mdu_done_n !== 1'b0) begin
                bad++;
                $display("FAIL nom_cycle%0d: got stall=%b msel=%b sel=%b done=%b expected 0,0,%b,0",
                         i, stall_n, mdu_sel_n, ALU_Selection_n, mdu_done_n, PASS);
            end
            if (i < 34) @(negedge clk);
        end
        total++; if (mdu_result_n !== 32'h0) begin bad++; $display("FAIL nom_result: got %h expected 0", mdu_result_n); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_decode();
        test_mdu_directed();
        test_mdu_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_calc();
        test_no_m();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
